fazyrv_cmp_seq: RTL
===================

# fazyrv_cmp_seq

Chunk-sequential compare unit for the FazyRV data path: consumes two XLEN-wide operands as BWIDTH-wide chunks (LSB chunk first), runs each chunk pair through the combinational `fazyrv_cmp` stage, and accumulates the per-chunk lower/greater/equal results into one branch/set-less-than decision. It sits directly downstream of the chunk comparator and feeds the branch-taken and SLT/SLTU result logic of the control unit.

## Interface
- `BWIDTH`, 2, chunk width; must divide `XLEN`.
- `XLEN`, 32, full operand width; `CHUNKS = XLEN/BWIDTH`.
- `clk_i`  in  1  core clock; all state updates on the rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `start_i`  in  1  begin a new comparison; samples `sgn_i`, `cond_i`, `neg_i`.
- `sgn_i`  in  1  signed compare (BLT/BGE/SLT) when high, unsigned otherwise.
- `cond_i`  in  1  0 = equality test, 1 = less-than test.
- `neg_i`  in  1  invert final result (BNE, BGE, BGEU).
- `vld_i`  in  1  chunk on `a_i`/`b_i` valid this cycle.
- `a_i`, `b_i`  in  BWIDTH  operand chunks, least-significant chunk first.
- `busy_o`  out  1  comparison in progress.
- `done_o`  out  1  one-cycle pulse: `res_o`, `lt_o`, `eq_o` final.
- `res_o`  out  1  selected, optionally inverted result.
- `lt_o`  out  1  a < b (signedness per `sgn_i`).
- `eq_o`  out  1  a == b.

## Operation
- States: IDLE, RUN, DONE. Reset → IDLE.
- IDLE: `start_i` → RUN; `cnt`←0, `lt`←0, `eq`←1; latch `sgn`, `cond`, `neg`.
- RUN, `vld_i`=1: drive `fazyrv_cmp` with the chunk, `inv_msb_i = sgn & (cnt == CHUNKS-1)`.
  - `lo_o` → `lt`←1; `gr_o` → `lt`←0; neither → `lt` unchanged (upper chunks dominate).
  - `eq`←`eq & (a_i == b_i)`.
  - `cnt`←`cnt+1`; at `cnt == CHUNKS-1` → DONE.
- RUN, `vld_i`=0: stall, no state change.
- DONE: one cycle, `done_o`=1, then IDLE. `vld_i` in DONE/IDLE is ignored.
- `res_o = (cond ? lt : eq) ^ neg`; `lt_o`, `eq_o`, `res_o` hold until the next `start_i` is accepted.
- `start_i` in any state restarts (aborts a running comparison, no `done_o`). `start_i` and `vld_i` in the same cycle: start wins, chunk dropped.
- `cnt` width `$clog2(CHUNKS)`, minimum 1; wraps only via restart/DONE, never by overflow.
- BWIDTH == XLEN (CHUNKS = 1): first chunk is also the MSB chunk; RUN lasts one accepted chunk.

## Timing
- Reset values: `busy_o`=0, `done_o`=0, `lt_o`=0, `eq_o`=1, `res_o`=`eq ^ neg` with `cond`=0, `neg`=0 → 1.
- `busy_o` high from the cycle after `start_i` through the cycle the last chunk is accepted.
- `done_o` asserted exactly one cycle after the last accepted chunk; minimum latency start→done = CHUNKS+1 cycles with `vld_i` held high.
- Asynchronous reset mid-RUN: immediately IDLE, outputs to reset values, no `done_o`.
- Purely registered outputs except `res_o` (one XOR/mux level after flops).

## Structure
- Shared package `fazyrv_pkg`: `CMP_EQ`/`CMP_LT` encodings for `cond_i`, state encoding localparams.
- One sub-module instance: `fazyrv_cmp` (`BWIDTH` passed through) for per-chunk lo/gr.
- Equality per chunk computed locally; no other sub-modules.

## Test plan (BWIDTH=2, XLEN=32, `vld_i` continuous unless stated)
- Unsigned LT: a=0x0000_0001, b=0x8000_0000, sgn=0, cond=1 → `done_o` at cycle 17, `lt_o`=1, `res_o`=1, `eq_o`=0.
- Signed LT: same operands, sgn=1 → `lt_o`=0, `res_o`=0; with neg=1 (BGE) → `res_o`=1.
- Equality: a=b=0xDEAD_BEEF, cond=0 → `eq_o`=1, `res_o`=1; neg=1 (BNE) → `res_o`=0.
- Stall: a=0xFFFF_FFFE, b=0xFFFF_FFFF, `vld_i` low every other cycle → `done_o` at cycle 32, `lt_o`=1, `busy_o` high throughout.
- Restart/abort: `start_i` again after 5 chunks → no `done_o`, new result after 16 further chunks; `start_i` with `vld_i` same cycle → chunk not counted.
- Reset mid-RUN after 8 chunks → outputs at reset values next edge, IDLE, later full compare correct.

Source files
------------

// File: rtl/fazyrv_pkg.sv
// Shared definitions for the FazyRV compare path.
// Provides the cond_i encodings (equality / less-than) and the state encoding
// of the chunk-sequential compare FSM.
package fazyrv_pkg;

  // cond_i encodings
  localparam logic CMP_EQ = 1'b0;
  localparam logic CMP_LT = 1'b1;

  // State encoding: bit 0 doubles as busy, bit 1 doubles as done, so both
  // outputs come straight off the state flops.
  localparam logic [1:0] ST_IDLE_ENC = 2'b00;
  localparam logic [1:0] ST_RUN_ENC  = 2'b01;
  localparam logic [1:0] ST_DONE_ENC = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE = ST_IDLE_ENC,
    ST_RUN  = ST_RUN_ENC,
    ST_DONE = ST_DONE_ENC
  } state_t;

endpackage

// File: rtl/fazyrv_cmp.sv
// Combinational chunk comparator: flags a < b and a > b for one chunk pair.
// Ports: a_i/b_i chunk operands, inv_msb_i flips both MSBs (signed top chunk),
//        lo_o = a < b, gr_o = a > b. No state, no latency.
module fazyrv_cmp #(
  parameter int BWIDTH = 2
) (
  input  logic [BWIDTH-1:0] a_i,
  input  logic [BWIDTH-1:0] b_i,
  input  logic              inv_msb_i,
  output logic              lo_o,
  output logic              gr_o
);

  logic [BWIDTH-1:0] a_m;
  logic [BWIDTH-1:0] b_m;

  // Flipping the sign bit of both operands maps two's-complement order onto
  // unsigned order, so one unsigned comparator serves both cases.
  always_comb begin
    a_m = a_i;
    b_m = b_i;
    a_m[BWIDTH-1] = a_i[BWIDTH-1] ^ inv_msb_i;
    b_m[BWIDTH-1] = b_i[BWIDTH-1] ^ inv_msb_i;
    lo_o = (a_m < b_m);
    gr_o = (a_m > b_m);
  end

endmodule

// File: rtl/fazyrv_cmp_seq.sv
// Chunk-sequential compare: accumulates per-chunk lo/gr/eq (LSB chunk first)
// into the branch / set-less-than decision.
// Ports: clk_i, rst_i (async, active-high); start_i with sgn_i/cond_i/neg_i
//        begins a compare; vld_i/a_i/b_i supply chunks; busy_o, done_o (pulse),
//        res_o, lt_o, eq_o report the result.
module fazyrv_cmp_seq
  import fazyrv_pkg::*;
#(
  parameter int BWIDTH = 2,
  parameter int XLEN   = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic              sgn_i,
  input  logic              cond_i,
  input  logic              neg_i,
  input  logic              vld_i,
  input  logic [BWIDTH-1:0] a_i,
  input  logic [BWIDTH-1:0] b_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              res_o,
  output logic              lt_o,
  output logic              eq_o
);

  localparam int CHUNKS = XLEN / BWIDTH;
  localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
  localparam logic [CW-1:0] LAST = CW'(CHUNKS - 1);

  state_t        state, state_n;
  logic [CW-1:0] cnt;
  logic          lt, eq;
  logic          sgn, cond, neg;
  logic          lo, gr;
  logic          last_chunk;
  logic          accept;

  assign last_chunk = (cnt == LAST);
  // A chunk only counts in RUN and never in the cycle a restart is requested.
  assign accept     = (state == ST_RUN) && vld_i && !start_i;

  fazyrv_cmp #(
    .BWIDTH (BWIDTH)
  ) u_cmp (
    .a_i       (a_i),
    .b_i       (b_i),
    .inv_msb_i (sgn & last_chunk),
    .lo_o      (lo),
    .gr_o      (gr)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; start_i restarts from any state.
  always_comb begin
    state_n = state;
    if (start_i) begin
      state_n = ST_RUN;
    end else begin
      case (state)
        ST_IDLE: state_n = ST_IDLE;
        ST_RUN:  if (vld_i && last_chunk) state_n = ST_DONE;
        ST_DONE: state_n = ST_IDLE;
        default: state_n = ST_IDLE;
      endcase
    end
  end

  // Accumulator and latched compare mode
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt  <= '0;
      lt   <= 1'b0;
      eq   <= 1'b1;
      sgn  <= 1'b0;
      cond <= CMP_EQ;
      neg  <= 1'b0;
    end else if (start_i) begin
      cnt  <= '0;
      lt   <= 1'b0;
      eq   <= 1'b1;
      sgn  <= sgn_i;
      cond <= cond_i;
      neg  <= neg_i;
    end else if (accept) begin
      // A strictly ordered higher chunk overrides whatever lower chunks said;
      // an equal chunk leaves the lower-chunk verdict standing.
      if (lo) begin
        lt <= 1'b1;
      end else if (gr) begin
        lt <= 1'b0;
      end
      eq  <= eq & (a_i == b_i);
      cnt <= last_chunk ? '0 : cnt + CW'(1);
    end
  end

  assign busy_o = state[0];
  assign done_o = state[1];
  assign lt_o   = lt;
  assign eq_o   = eq;
  assign res_o  = ((cond == CMP_LT) ? lt : eq) ^ neg;

endmodule
